// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers: slot states, bubble control, control-bundle layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int unsigned CTRL_W_DEF = 24;

  // Bubble control word: every field deasserted, so a bubble has no side effects.
  localparam logic [CTRL_W_DEF-1:0] NOP_CTRL_DEF = '0;

  // Control-bundle field offsets shared by all stages.
  localparam int unsigned CTRL_HALT_BIT   = 0;
  localparam int unsigned CTRL_REGWRT_BIT = 1;
  localparam int unsigned CTRL_MEMWRT_BIT = 2;
  localparam int unsigned CTRL_MEMEN_BIT  = 3;
  localparam int unsigned CTRL_ALUOP_LSB  = 4;
  localparam int unsigned CTRL_ALUOP_W    = 4;

  // Assemble a control bundle from its named fields.
  function automatic logic [CTRL_W_DEF-1:0] ctrl_pack(
    input logic                    halt,
    input logic                    reg_wrt,
    input logic                    mem_wrt,
    input logic                    mem_en,
    input logic [CTRL_ALUOP_W-1:0] alu_op
  );
    logic [CTRL_W_DEF-1:0] c;
    c = '0;
    c[CTRL_HALT_BIT]   = halt;
    c[CTRL_REGWRT_BIT] = reg_wrt;
    c[CTRL_MEMWRT_BIT] = mem_wrt;
    c[CTRL_MEMEN_BIT]  = mem_en;
    c[CTRL_ALUOP_LSB +: CTRL_ALUOP_W] = alu_op;
    return c;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag plus data and control, with load and clear.
module pipe_slot #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Clear wins over load; a cleared slot keeps its data so nothing goes X downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= NOP_CTRL;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= NOP_CTRL;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid, flush and stall counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(NOP_CTRL_DEF),
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state;
  logic              acc;
  logic              pop;
  logic              m_load;
  logic              m_clear;
  logic              m_from_s;
  logic              s_load;
  logic              s_clear;
  logic              m_valid;
  logic              s_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] m_load_data;
  logic [CTRL_W-1:0] m_load_ctrl;

  assign out_valid = m_valid;
  assign in_ready  = ~s_valid;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = m_data;
  assign out_ctrl  = out_valid ? m_ctrl : NOP_CTRL;

  assign m_load_data = m_from_s ? s_data : in_data;
  assign m_load_ctrl = m_from_s ? s_ctrl : in_ctrl;

  // Occupancy state; flush overrides every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (acc) state <= ST_ONE;
        ST_ONE: begin
          if (acc && !pop)      state <= ST_TWO;
          else if (!acc && pop) state <= ST_EMPTY;
        end
        ST_TWO:   if (pop) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Slot load/clear controls derived from the current occupancy.
  always_comb begin
    m_load   = 1'b0;
    m_clear  = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clear  = 1'b0;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: m_load = acc;
        ST_ONE: begin
          if (acc && pop)  m_load  = 1'b1;
          else if (pop)    m_clear = 1'b1;
          else if (acc)    s_load  = 1'b1;
        end
        ST_TWO: begin
          if (pop) begin
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clear  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP_CTRL)) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (m_load),
    .clear     (m_clear),
    .load_data (m_load_data),
    .load_ctrl (m_load_ctrl),
    .valid     (m_valid),
    .data      (m_data),
    .ctrl      (m_ctrl)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP_CTRL)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (s_load),
    .clear     (s_clear),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .valid     (s_valid),
    .data      (s_data),
    .ctrl      (s_ctrl)
  );

  // Saturating count of stalled cycles; clear beats increment, flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed table, corner-case sequences, randomized run against a queue model.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 24;
  localparam int unsigned NW = 4;
  localparam logic [CW-1:0] NOP = '0;
  localparam int unsigned CNT_MAX = (1 << NW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush;
  logic          cnt_clr;
  logic [NW-1:0] stall_cnt;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO of accepted beats (capacity 2), last front data, saturating counter.
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;
  beat_t mq[$];
  logic [DW-1:0] m_last_d = '0;
  int            m_cnt = 0;
  logic          m_acc = 1'b0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          fl;
    logic          clr;
    logic          e_ov;
    logic [DW-1:0] e_d;
    logic [CW-1:0] e_c;
    logic          e_ir;
    logic [NW-1:0] e_cnt;
  } vec_t;
  vec_t tab[$];

  function automatic logic [CW-1:0] mk_ctrl(input logic [DW-1:0] d);
    return ctrl_pack(1'b0, 1'b1, d[0], 1'b1, d[3:0]) | {8'hC3, 16'h0000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last_d = '0;
    m_cnt = 0;
    m_acc = 1'b0;
  endtask

  // Drive one cycle of inputs, clock it, then advance the model.
  task automatic drive_edge(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                            input logic ordy, input logic fl, input logic clr);
    logic  pop;
    logic  stall;
    beat_t b;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    m_acc = iv && (mq.size() < 2);
    pop   = (mq.size() > 0) && ordy;
    stall = (mq.size() > 0) && !ordy;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_acc) begin
        b.d = d;
        b.c = c;
        mq.push_back(b);
      end
    end
    if (mq.size() > 0) m_last_d = mq[0].d;
    if (clr) m_cnt = 0;
    else if (stall && m_cnt < int'(CNT_MAX)) m_cnt++;
  endtask

  task automatic check_model(input string tag);
    logic          e_ov;
    logic [CW-1:0] e_c;
    e_ov = mq.size() > 0;
    e_c  = e_ov ? mq[0].c : NOP;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, "_out_data"},  32'(out_data),  32'(m_last_d));
    chk({tag, "_out_ctrl"},  32'(out_ctrl),  32'(e_c));
    chk({tag, "_in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_in_ready"},  32'(in_ready),  32'(1));
    chk({tag, "_out_data"},  32'(out_data),  32'(0));
    chk({tag, "_out_ctrl"},  32'(out_ctrl),  32'(NOP));
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(0));
  endtask

  task automatic add(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy,
                     input logic e_ov, input logic [DW-1:0] e_d, input logic [CW-1:0] e_c,
                     input logic e_ir, input logic [NW-1:0] e_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = 1'b0; v.clr = 1'b0;
    v.e_ov = e_ov; v.e_d = e_d; v.e_c = e_c; v.e_ir = e_ir; v.e_cnt = e_cnt;
    tab.push_back(v);
  endtask

  initial begin
    logic          p_iv;
    logic [DW-1:0] p_d;
    logic [CW-1:0] p_c;
    logic          r_ordy;
    logic          r_fl;
    logic          r_clr;
    logic          last_fl;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    model_reset();

    // Streaming: one beat per cycle, each visible one cycle after it is offered.
    for (int k = 1; k <= 8; k++)
      add(1'b1, DW'(k), mk_ctrl(DW'(k)), 1'b1, 1'b1, DW'(k), mk_ctrl(DW'(k)), 1'b1, NW'(0));
    add(1'b0, 16'h0000, '0, 1'b1, 1'b0, 16'h0008, NOP, 1'b1, NW'(0));
    // Stall with skid: 0x10 held, 0x11 captured in the skid slot, then both drain in order.
    add(1'b1, 16'h0010, mk_ctrl(16'h0010), 1'b1, 1'b1, 16'h0010, mk_ctrl(16'h0010), 1'b1, NW'(0));
    add(1'b1, 16'h0011, mk_ctrl(16'h0011), 1'b0, 1'b1, 16'h0010, mk_ctrl(16'h0010), 1'b0, NW'(1));
    add(1'b0, 16'h0000, '0, 1'b0, 1'b1, 16'h0010, mk_ctrl(16'h0010), 1'b0, NW'(2));
    add(1'b0, 16'h0000, '0, 1'b0, 1'b1, 16'h0010, mk_ctrl(16'h0010), 1'b0, NW'(3));
    add(1'b0, 16'h0000, '0, 1'b1, 1'b1, 16'h0011, mk_ctrl(16'h0011), 1'b1, NW'(3));
    add(1'b0, 16'h0000, '0, 1'b1, 1'b0, 16'h0011, NOP, 1'b1, NW'(3));
    // Bubble masking with an all-ones control word on the idle input.
    add(1'b0, 16'h0000, '1, 1'b1, 1'b0, 16'h0011, NOP, 1'b1, NW'(3));
    add(1'b0, 16'h0000, '1, 1'b0, 1'b0, 16'h0011, NOP, 1'b1, NW'(3));

    for (int i = 0; i < tab.size(); i++) begin
      drive_edge(tab[i].iv, tab[i].d, tab[i].c, tab[i].ordy, tab[i].fl, tab[i].clr);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tab[i].e_ov));
      chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tab[i].e_d));
      chk($sformatf("vec%0d_out_ctrl", i),  32'(out_ctrl),  32'(tab[i].e_c));
      chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(tab[i].e_ir));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(tab[i].e_cnt));
    end

    // Flush while both slots are full and 0x20 is offered.
    drive_edge(1'b1, 16'h001E, mk_ctrl(16'h001E), 1'b0, 1'b0, 1'b0);
    drive_edge(1'b1, 16'h001F, mk_ctrl(16'h001F), 1'b0, 1'b0, 1'b0);
    chk("flush_pre_in_ready", 32'(in_ready), 32'(0));
    drive_edge(1'b1, 16'h0020, mk_ctrl(16'h0020), 1'b0, 1'b1, 1'b0);
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    chk("flush_out_ctrl",  32'(out_ctrl),  32'(NOP));
    chk("flush_in_ready",  32'(in_ready),  32'(1));
    check_model("flush");
    for (int k = 0; k < 3; k++) begin
      drive_edge(1'b0, 16'h0000, '0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("flush_drain%0d_out_valid", k), 32'(out_valid), 32'(0));
      check_model("flush_drain");
    end

    // Counter saturation and clear-over-increment priority.
    drive_edge(1'b1, 16'h0030, mk_ctrl(16'h0030), 1'b0, 1'b0, 1'b1);
    chk("cnt_cleared", 32'(stall_cnt), 32'(0));
    for (int k = 0; k < 20; k++) drive_edge(1'b0, 16'h0000, '0, 1'b0, 1'b0, 1'b0);
    chk("cnt_saturated", 32'(stall_cnt), 32'(15));
    check_model("cnt_sat");
    drive_edge(1'b0, 16'h0000, '0, 1'b0, 1'b0, 1'b1);
    chk("cnt_clr_with_stall", 32'(stall_cnt), 32'(0));
    check_model("cnt_clr");

    // Asynchronous reset between edges while both slots are full.
    drive_edge(1'b0, 16'h0000, '0, 1'b1, 1'b1, 1'b0);
    drive_edge(1'b1, 16'h0040, mk_ctrl(16'h0040), 1'b0, 1'b0, 1'b0);
    drive_edge(1'b1, 16'h0041, mk_ctrl(16'h0041), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_in_ready", 32'(in_ready), 32'(0));
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    rst = 1'b0;
    model_reset();
    drive_edge(1'b1, 16'h0042, mk_ctrl(16'h0042), 1'b1, 1'b0, 1'b0);
    chk("post_rst_accept", 32'(out_data), 32'(16'h0042));
    check_model("post_rst");

    // Randomized traffic; an unaccepted beat is held until taken or flushed.
    p_iv = 1'b0; p_d = '0; p_c = '0; last_fl = 1'b0;
    m_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(p_iv && !m_acc && !last_fl)) begin
        p_iv = $urandom_range(0, 9) < 6;
        p_d  = DW'($urandom);
        p_c  = CW'($urandom);
      end
      r_ordy = $urandom_range(0, 9) < 6;
      r_fl   = $urandom_range(0, 99) < 3;
      r_clr  = $urandom_range(0, 99) < 2;
      drive_edge(p_iv, p_d, p_c, r_ordy, r_fl, r_clr);
      last_fl = r_fl;
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
